// File: rtl/adc_conv_scheduler.sv
// adc_conv_scheduler: round-robin sharing of one SAR ADC between NUM_REQ requesters.
// Define ADC_SCHED_TIMEOUT_EN to add a TIMEOUT_CYCLES conversion watchdog.
module adc_conv_scheduler #(
   parameter int NUM_BITS       = 4,
   parameter int NUM_REQ        = 4,
   parameter int SETTLE_CYCLES  = 2,
   parameter int TIMEOUT_CYCLES = 64,
   localparam int IDW = $clog2(NUM_REQ)
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic [NUM_REQ-1:0]   req_i,
   input  logic [2*NUM_REQ-1:0] req_rate_i,
   output logic [NUM_REQ-1:0]   grant_o,
   output logic                 rsp_valid_o,
   output logic [IDW-1:0]       rsp_id_o,
   output logic [NUM_BITS-1:0]  rsp_data_o,
   output logic                 rsp_timeout_o,
   output logic                 busy_o,
   output logic                 adc_rst_n_o,
   output logic [1:0]           adc_sample_rate_o,
   output logic [IDW-1:0]       adc_mux_sel_o,
   input  logic [NUM_BITS-1:0]  adc_d_out_i,
   input  logic                 adc_eoc_i
);
   localparam int SW = $clog2(SETTLE_CYCLES + 1);
   localparam logic [SW-1:0] SET_LAST = SW'(SETTLE_CYCLES - 1);
   typedef enum logic [1:0] {IDLE, SETTLE, CONV, DONE} state_t;
   state_t state_q, state_d;
   logic [IDW-1:0] rr_ptr_q, rr_ptr_d, win;
   logic [SW-1:0] settle_q, settle_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic rsp_valid_q, rsp_valid_d, busy_q, busy_d, adc_rst_n_q, adc_rst_n_d;
   logic [IDW-1:0] rsp_id_q, rsp_id_d, mux_q, mux_d;
   logic [NUM_BITS-1:0] rsp_data_q, rsp_data_d;
   logic [1:0] rate_q, rate_d;
`ifdef ADC_SCHED_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
   logic [TW-1:0] wdog_q, wdog_d;
   logic rsp_timeout_q, rsp_timeout_d;
`endif

   if (NUM_REQ < 2 || SETTLE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
      $error("adc_conv_scheduler: invalid parameter value");
   end

   // Descending scan, last hit wins: the first set bit at or after rr_ptr.
   always_comb begin
      win = rr_ptr_q;
      for (int i = NUM_REQ - 1; i >= 0; i--)
         if (req_i[(int'(rr_ptr_q) + i) % NUM_REQ]) win = IDW'((int'(rr_ptr_q) + i) % NUM_REQ);
   end

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      settle_d    = settle_q;
      grant_d     = '0;
      rsp_valid_d = 1'b0;
      rsp_id_d    = rsp_id_q;
      rsp_data_d  = rsp_data_q;
      adc_rst_n_d = 1'b0;
      rate_d      = rate_q;
      mux_d       = mux_q;
`ifdef ADC_SCHED_TIMEOUT_EN
      wdog_d        = wdog_q;
      rsp_timeout_d = rsp_timeout_q;
`endif
      case (state_q)
         IDLE: if (|req_i) begin
            state_d      = SETTLE;
            grant_d[win] = 1'b1;
            mux_d        = win;
            rate_d       = req_rate_i[2*win +: 2];
            rr_ptr_d     = IDW'((int'(win) + 1) % NUM_REQ);
            settle_d     = '0;
         end
         SETTLE: if (settle_q == SET_LAST) begin
            state_d     = CONV;
            adc_rst_n_d = 1'b1;
`ifdef ADC_SCHED_TIMEOUT_EN
            wdog_d = '0;
`endif
         end else settle_d = settle_q + 1'b1;
         CONV: begin
            adc_rst_n_d = 1'b1;
            if (adc_eoc_i) begin
               state_d     = DONE;
               rsp_valid_d = 1'b1;
               rsp_id_d    = mux_q;
               rsp_data_d  = adc_d_out_i;
               adc_rst_n_d = 1'b0;
`ifdef ADC_SCHED_TIMEOUT_EN
               rsp_timeout_d = 1'b0;
            end else if (wdog_q == TO_LAST) begin
               state_d       = DONE;
               rsp_valid_d   = 1'b1;
               rsp_id_d      = mux_q;
               rsp_data_d    = '0;
               rsp_timeout_d = 1'b1;
               adc_rst_n_d   = 1'b0;
            end else wdog_d = wdog_q + 1'b1;
`else
            end
`endif
         end
         default: state_d = IDLE;
      endcase
      busy_d = state_d != IDLE;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         settle_q    <= '0;
         grant_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_data_q  <= '0;
         busy_q      <= 1'b0;
         adc_rst_n_q <= 1'b0;
         rate_q      <= '0;
         mux_q       <= '0;
`ifdef ADC_SCHED_TIMEOUT_EN
         wdog_q        <= '0;
         rsp_timeout_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         settle_q    <= settle_d;
         grant_q     <= grant_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_data_q  <= rsp_data_d;
         busy_q      <= busy_d;
         adc_rst_n_q <= adc_rst_n_d;
         rate_q      <= rate_d;
         mux_q       <= mux_d;
`ifdef ADC_SCHED_TIMEOUT_EN
         wdog_q        <= wdog_d;
         rsp_timeout_q <= rsp_timeout_d;
`endif
      end
   end

   assign grant_o           = grant_q;
   assign rsp_valid_o       = rsp_valid_q;
   assign rsp_id_o          = rsp_id_q;
   assign rsp_data_o        = rsp_data_q;
   assign busy_o            = busy_q;
   assign adc_rst_n_o       = adc_rst_n_q;
   assign adc_sample_rate_o = rate_q;
   assign adc_mux_sel_o     = mux_q;
`ifdef ADC_SCHED_TIMEOUT_EN
   assign rsp_timeout_o = rsp_timeout_q;
`else
   assign rsp_timeout_o = 1'b0;
`endif
endmodule
